mem_stage_lsu: RTL and testbench

Load/store unit for the memory stage of the five-stage MIPS pipeline. Takes the M-stage address (`aluoutM`) and raw store data (`writedataM`) produced by the execute→mem pipeline register and drives an SRAM-like data bus with an address/data two-phase handshake. It returns aligned, sign/zero-extended load data as `readdataM` to the mem→writeback register. While a transaction is outstanding it stalls the pipeline, and it flags misaligned accesses instead of issuing them.

---
 rtl/mem_stage_lsu.sv | 136 +++++++++++++
 tb/tb_mem_stage_lsu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit with two-phase SRAM-like bus handshake
module mem_stage_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en_M,
   input  logic        mem_we_M,
   input  logic [1:0]  mem_size_M,
   input  logic        mem_sign_M,
   input  logic [31:0] aluoutM,
   input  logic [31:0] writedataM,
   input  logic        stall_ext,
   output logic [31:0] readdataM,
   output logic        stallM,
   output logic        adelM,
   output logic        adesM,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WAIT_ADDR = 2'd1;
   localparam logic [1:0] S_WAIT_DATA = 2'd2;
   localparam logic [1:0] S_DONE      = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] rd_q, rd_d;
   logic        misal;
   logic        go;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Alignment check: halfwords need addr[0]=0, words (and the illegal size 11) need addr[1:0]=0
   always_comb begin
      misal = 1'b0;
      case (mem_size_M)
         2'b00:   misal = 1'b0;
         2'b01:   misal = aluoutM[0];
         default: misal = |aluoutM[1:0];
      endcase
   end

   assign go     = mem_en_M & ~misal;
   assign adelM  = mem_en_M & ~mem_we_M & misal;
   assign adesM  = mem_en_M &  mem_we_M & misal;

   // DONE is the cycle the result is presented, so the stage is released there
   assign stallM = go & (state_q != S_DONE);

   assign data_wr   = mem_we_M;
   assign data_size = mem_size_M;
   assign data_addr = aluoutM;

   // Store data replicated across all byte lanes so the bus can pick by address
   always_comb begin
      data_wdata = writedataM;
      case (mem_size_M)
         2'b00:   data_wdata = {4{writedataM[7:0]}};
         2'b01:   data_wdata = {2{writedataM[15:0]}};
         default: data_wdata = writedataM;
      endcase
   end

   // Handshake FSM: request until address accepted, then wait for data, then present result
   always_comb begin
      state_d  = state_q;
      rd_d     = rd_q;
      data_req = 1'b0;
      case (state_q)
         S_IDLE: begin
            data_req = go;
            if (go) begin
               state_d = data_addr_ok ? S_WAIT_DATA : S_WAIT_ADDR;
            end
         end
         S_WAIT_ADDR: begin
            data_req = 1'b1;
            if (data_addr_ok) begin
               state_d = S_WAIT_DATA;
            end
         end
         S_WAIT_DATA: begin
            if (data_data_ok) begin
               rd_d    = data_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!stall_ext) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and captured read word; reset abandons any in-flight transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rd_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
      end
   end

   // Lane selection from the captured word using the still-held M-stage address
   always_comb begin
      byte_v = rd_q[7:0];
      case (aluoutM[1:0])
         2'b00: byte_v = rd_q[7:0];
         2'b01: byte_v = rd_q[15:8];
         2'b10: byte_v = rd_q[23:16];
         2'b11: byte_v = rd_q[31:24];
         default: byte_v = rd_q[7:0];
      endcase
      half_v = aluoutM[1] ? rd_q[31:16] : rd_q[15:0];
   end

   // Sign/zero extension of the selected lane; words pass straight through
   always_comb begin
      readdataM = rd_q;
      case (mem_size_M)
         2'b00:   readdataM = {{24{mem_sign_M & byte_v[7]}}, byte_v};
         2'b01:   readdataM = {{16{mem_sign_M & half_v[15]}}, half_v};
         default: readdataM = rd_q;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized self-checking bench for mem_stage_lsu against a behavioural model
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en_M, mem_we_M, mem_sign_M, stall_ext;
   logic [1:0]  mem_size_M;
   logic [31:0] aluoutM, writedataM;
   logic [31:0] readdataM;
   logic        stallM, adelM, adesM;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;

   int n_cmp  = 0;
   int n_fail = 0;

   logic        exp_on = 1'b0;
   logic        exp_stall, exp_req, exp_adel, exp_ades, exp_rd_on;
   logic [31:0] exp_rd, exp_wdata;

   always #5 clk = ~clk;

   mem_stage_lsu dut (
      .clk(clk), .rst(rst),
      .mem_en_M(mem_en_M), .mem_we_M(mem_we_M), .mem_size_M(mem_size_M), .mem_sign_M(mem_sign_M),
      .aluoutM(aluoutM), .writedataM(writedataM), .stall_ext(stall_ext),
      .readdataM(readdataM), .stallM(stallM), .adelM(adelM), .adesM(adesM),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Load result: the addressed lane as an unsigned number, then extended by arithmetic
   function automatic logic [31:0] fmt(input logic [31:0] rd, input logic [1:0] sz,
                                       input logic sg, input logic [31:0] addr);
      logic [31:0] v;
      if (sz == 2'b00) begin
         v = (rd >> (int'(addr[1:0]) * 8)) & 32'hFF;
         if (sg && v >= 32'h80) v = v + 32'hFFFFFF00;
      end else if (sz == 2'b01) begin
         v = (rd >> (int'(addr[1]) * 16)) & 32'hFFFF;
         if (sg && v >= 32'h8000) v = v + 32'hFFFF0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // Store data: replicate by multiplication with a lane-repeat constant
   function automatic logic [31:0] repl(input logic [1:0] sz, input logic [31:0] wd);
      if (sz == 2'b00) return (wd & 32'hFF) * 32'h01010101;
      if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h00010001;
      return wd;
   endfunction

   // Per-cycle comparison against the expectations the driver publishes
   always @(negedge clk) begin
      if (exp_on) begin
         chk("stallM", {31'b0, stallM}, {31'b0, exp_stall});
         chk("data_req", {31'b0, data_req}, {31'b0, exp_req});
         chk("adelM", {31'b0, adelM}, {31'b0, exp_adel});
         chk("adesM", {31'b0, adesM}, {31'b0, exp_ades});
         chk("data_wdata", data_wdata, exp_wdata);
         chk("data_addr", data_addr, aluoutM);
         chk("data_size", {30'b0, data_size}, {30'b0, mem_size_M});
         chk("data_wr", {31'b0, data_wr}, {31'b0, mem_we_M});
         if (exp_rd_on) chk("readdataM", readdataM, exp_rd);
      end
   end

   task automatic idle(input int n, input logic zero_chk);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         rst = 1'b0; mem_en_M = 1'b0; mem_we_M = 1'b0; mem_size_M = 2'b00; mem_sign_M = 1'b0;
         aluoutM = $urandom; writedataM = 32'd0; stall_ext = 1'($urandom_range(0, 1));
         data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
         exp_stall = 1'b0; exp_req = 1'b0; exp_adel = 1'b0; exp_ades = 1'b0;
         exp_wdata = 32'd0; exp_rd_on = zero_chk; exp_rd = 32'd0; exp_on = 1'b1;
         @(negedge clk);
      end
   endtask

   // One M-stage op: address accepted da cycles after first request, data dd cycles later,
   // then stall_ext held for hold cycles in the result cycle
   task automatic do_op(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int da, input int dd, input int hold,
                        output int stalls, output logic [31:0] res, output int accs,
                        output logic [31:0] wd_s, output logic [1:0] errs);
      logic mis, go;
      int   n, t;
      mis = (sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
      go  = !mis;
      t   = da + dd;
      n   = go ? t + 2 + hold : 1;
      stalls = 0; accs = 0; res = 32'd0; wd_s = 32'd0; errs = 2'b00;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         rst = 1'b0; mem_en_M = 1'b1; mem_we_M = we; mem_size_M = sz; mem_sign_M = sg;
         aluoutM = addr; writedataM = wd;
         data_addr_ok = go && (k == da);
         data_data_ok = go && (k == t);
         data_rdata   = (go && k == t) ? rd : $urandom;
         if (go && k > t && k <= t + hold) stall_ext = 1'b1;
         else if (go && k <= t)            stall_ext = 1'($urandom_range(0, 1));
         else                              stall_ext = 1'b0;
         exp_stall = go && (k <= t);
         exp_req   = go && (k <= da);
         exp_adel  = mis && !we;
         exp_ades  = mis && we;
         exp_wdata = repl(sz, wd);
         exp_rd_on = go && !we && (k > t);
         exp_rd    = fmt(rd, sz, sg, addr);
         exp_on    = 1'b1;
         @(negedge clk);
         if (stallM) stalls++;
         if (data_req && data_addr_ok) accs++;
         if (k == 0) begin wd_s = data_wdata; errs = {adelM, adesM}; end
         res = readdataM;
      end
   endtask

   int          st, ac;
   logic [31:0] rs, ws;
   logic [1:0]  er;

   initial begin
      rst = 1'b1; mem_en_M = 1'b0; mem_we_M = 1'b0; mem_size_M = 2'b00; mem_sign_M = 1'b0;
      aluoutM = 32'd0; writedataM = 32'd0; stall_ext = 1'b0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
      exp_stall = 1'b0; exp_req = 1'b0; exp_adel = 1'b0; exp_ades = 1'b0;
      exp_rd_on = 1'b0; exp_rd = 32'd0; exp_wdata = 32'd0;
      repeat (3) @(posedge clk);
      idle(2, 1'b1);

      // Best-case word load
      do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'h8899AABB, 0, 1, 0, st, rs, ac, ws, er);
      chk("wload_stalls", st, 2);
      chk("wload_data", rs, 32'h8899AABB);
      chk("wload_accepts", ac, 1);

      do_op(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 32'h80123456, 0, 1, 0, st, rs, ac, ws, er);
      chk("lb_signed", rs, 32'hFFFFFF80);
      do_op(1'b0, 2'b01, 1'b0, 32'h102, 32'd0, 32'h80123456, 1, 2, 0, st, rs, ac, ws, er);
      chk("lhu", rs, 32'h00008012);
      chk("lhu_stalls", st, 4);

      do_op(1'b1, 2'b00, 1'b0, 32'h201, 32'h000000A5, 32'h0, 3, 1, 0, st, rs, ac, ws, er);
      chk("sb_wdata", ws, 32'hA5A5A5A5);
      chk("sb_stalls", st, 5);

      do_op(1'b0, 2'b01, 1'b0, 32'h301, 32'd0, 32'h0, 0, 1, 0, st, rs, ac, ws, er);
      chk("lh_mis_err", {30'b0, er}, 32'd2);
      chk("lh_mis_stalls", st, 0);
      chk("lh_mis_accepts", ac, 0);
      do_op(1'b1, 2'b10, 1'b0, 32'h302, 32'h12345678, 32'h0, 0, 1, 0, st, rs, ac, ws, er);
      chk("sw_mis_err", {30'b0, er}, 32'd1);
      chk("sw_mis_accepts", ac, 0);

      // Result held under external stall, then an immediate follow-on load
      do_op(1'b0, 2'b10, 1'b0, 32'h500, 32'd0, 32'hCAFEF00D, 0, 1, 2, st, rs, ac, ws, er);
      chk("hold_accepts", ac, 1);
      chk("hold_data", rs, 32'hCAFEF00D);
      do_op(1'b0, 2'b00, 1'b0, 32'h502, 32'd0, 32'h00EE0000, 0, 1, 0, st, rs, ac, ws, er);
      chk("after_hold_stalls", st, 2);
      chk("after_hold_data", rs, 32'h000000EE);

      // Reset while waiting for data
      @(posedge clk); #1;
      exp_on = 1'b0; mem_en_M = 1'b1; mem_we_M = 1'b0; mem_size_M = 2'b10; aluoutM = 32'h400;
      stall_ext = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b0;
      @(posedge clk); #1;
      data_addr_ok = 1'b0; rst = 1'b1;
      idle(1, 1'b1);
      do_op(1'b0, 2'b10, 1'b0, 32'h404, 32'd0, 32'h13579BDF, 0, 1, 0, st, rs, ac, ws, er);
      chk("post_rst_data", rs, 32'h13579BDF);
      chk("post_rst_stalls", st, 2);

      // Randomized ops, back to back with occasional gaps
      for (int i = 0; i < 300; i++) begin
         logic [1:0]  sz;
         logic [31:0] ad;
         logic        ms;
         sz = 2'($urandom_range(0, 3));
         ad = $urandom;
         ms = (sz == 2'b01 && ad[0]) || (sz[1] && ad[1:0] != 2'b00);
         do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2), st, rs, ac, ws, er);
         chk("rand_accepts", ac, ms ? 0 : 1);
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2), 1'b0);
      end

      exp_on = 1'b0;
      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
